wishbone_config_sequencer: RTL and testbench

WISHBONE_CONFIG_SEQUENCER -- requirements
Module: wishbone_config_sequencer

---
 rtl/wishbone_config_sequencer.sv | 255 +++++++++++++++++++++++++
 tb/tb_wishbone_config_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_config_sequencer.sv
// Wishbone-programmed sequencer that streams queued 32-bit words into
// NUM_CHAINS parallel serial config chains, then pulses a common latch strobe.
module wishbone_config_sequencer #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int unsigned NUM_CHAINS = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_data_i,
  input  logic [31:0]           wbs_addr_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_data_o,
  output logic                  cen,
  output logic                  shift_en_out,
  output logic [NUM_CHAINS-1:0] shift_out,
  output logic                  set_out,
  output logic                  busy
);

  localparam int unsigned STEPS  = 32 / NUM_CHAINS;
  localparam int unsigned STEP_W = $clog2(STEPS);
  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CW     = AW + 1;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_LEN  = 2'd1;
  localparam logic [1:0] REG_DATA = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_SET   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic        hit;
  logic        req;
  logic        wr;
  logic        rd;
  logic [1:0]  offset;
  logic        ctrl_wr;
  logic        len_wr;
  logic        data_wr;
  logic        stat_wr;
  logic        unused_addr;

  assign hit     = (wbs_addr_i[31:24] == BASE_ADDR[31:24]);
  // A request still held during its own ack cycle is not accepted again.
  assign req     = wbs_stb_i & wbs_cyc_i & hit & ~wbs_ack_o;
  assign wr      = req & wbs_we_i;
  assign rd      = req & ~wbs_we_i;
  assign offset  = wbs_addr_i[3:2];
  assign ctrl_wr = wr & (offset == REG_CTRL);
  assign len_wr  = wr & (offset == REG_LEN);
  assign data_wr = wr & (offset == REG_DATA);
  assign stat_wr = wr & (offset == REG_STAT);

  assign unused_addr = ^{wbs_addr_i[23:4], wbs_addr_i[1:0]};

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] length;
  logic             go;
  logic             ovf;
  logic             ovf_clr;
  logic [31:0]      lane_mask;
  logic [31:0]      len_merged;
  logic [31:0]      rdata;

  assign lane_mask  = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                       {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign len_merged = (32'(length) & ~lane_mask) | (wbs_data_i & lane_mask);
  assign ovf_clr    = stat_wr & wbs_sel_i[0] & wbs_data_i[3];

  // ---------------------------------------------------------------------------
  // Word FIFO
  // ---------------------------------------------------------------------------
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push_ok;
  logic          drop;
  logic [31:0]   head;

  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign drop    = data_wr & full & ~pop;
  assign push_ok = data_wr & ~drop;
  assign head    = mem[rd_ptr];

  // Read-data multiplexer for the four word offsets.
  always_comb begin
    rdata = '0;
    case (offset)
      REG_CTRL: rdata = {31'd0, cen};
      REG_LEN:  rdata = 32'(length);
      REG_DATA: rdata = '0;
      REG_STAT: rdata = {16'd0, 8'(count), 4'd0, ovf, full, empty, busy};
      default:  rdata = '0;
    endcase
  end

  // Bus response and control/length register updates.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o  <= 1'b0;
      wbs_data_o <= '0;
      cen        <= 1'b0;
      go         <= 1'b0;
      length     <= '0;
    end else begin
      wbs_ack_o  <= req;
      wbs_data_o <= rd ? rdata : '0;
      go         <= ctrl_wr & wbs_sel_i[0] & wbs_data_i[1];
      if (ctrl_wr && wbs_sel_i[0]) begin
        cen <= wbs_data_i[0];
      end
      if (len_wr) begin
        length <= CNT_W'(len_merged);
      end
    end
  end

  // Sticky overflow flag; a dropped push takes priority over a clear.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  // FIFO storage.
  always_ff @(posedge wb_clk_i) begin
    if (push_ok) begin
      mem[wr_ptr] <= wbs_data_i;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  state_t            state;
  state_t            state_n;
  logic [CNT_W-1:0]  remaining;
  logic [CNT_W-1:0]  remaining_n;
  logic [STEP_W-1:0] step;
  logic [STEP_W-1:0] step_n;
  logic [31:0]       word;
  logic [31:0]       word_n;

  // Next-state logic; the shifter always presents its next slice in the low bits.
  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    step_n      = step;
    word_n      = word;
    pop         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (go) begin
          remaining_n = length;
          state_n     = (length == '0) ? ST_SET : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (!empty) begin
          pop     = 1'b1;
          word_n  = head;
          step_n  = '0;
          state_n = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        remaining_n = remaining - CNT_W'(1);
        step_n      = step + STEP_W'(1);
        word_n      = word >> NUM_CHAINS;
        if (remaining == CNT_W'(1)) begin
          state_n = ST_SET;
        end else if (step == STEP_W'(STEPS - 1)) begin
          state_n = ST_LOAD;
        end
      end
      ST_SET: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State register and registered chain outputs, aligned with the state.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state        <= ST_IDLE;
      remaining    <= '0;
      step         <= '0;
      word         <= '0;
      busy         <= 1'b0;
      set_out      <= 1'b0;
      shift_en_out <= 1'b0;
      shift_out    <= '0;
    end else begin
      state        <= state_n;
      remaining    <= remaining_n;
      step         <= step_n;
      word         <= word_n;
      busy         <= (state_n != ST_IDLE);
      set_out      <= (state_n == ST_SET);
      shift_en_out <= (state_n == ST_SHIFT);
      shift_out    <= (state_n == ST_SHIFT) ? word_n[NUM_CHAINS-1:0] : '0;
    end
  end

endmodule

// File: tb/tb_wishbone_config_sequencer.sv
// Self-checking bench for wishbone_config_sequencer (default parameters).
module tb_wishbone_config_sequencer;

  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam int          NC    = 4;
  localparam int          DEPTH = 4;
  localparam logic [1:0]  R_CTRL = 2'd0;
  localparam logic [1:0]  R_LEN  = 2'd1;
  localparam logic [1:0]  R_DATA = 2'd2;
  localparam logic [1:0]  R_STAT = 2'd3;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic        stb  = 1'b0;
  logic        cyc  = 1'b0;
  logic        we   = 1'b0;
  logic [3:0]  sel  = 4'h0;
  logic [31:0] wdat = 32'd0;
  logic [31:0] addr = 32'd0;
  logic        ack;
  logic [31:0] rdat;
  logic        cen;
  logic        shift_en;
  logic [NC-1:0] shift_o;
  logic        set_o;
  logic        busy_o;

  int checks   = 0;
  int failures = 0;

  // Observed chain traffic (written only by the monitor) and the FIFO model.
  logic [3:0]  obs_q[$];
  int          set_cnt   = 0;
  int          zero_viol = 0;
  logic [31:0] mq[$];

  always #5 clk = ~clk;

  wishbone_config_sequencer #(
    .BASE_ADDR (BASE),
    .NUM_CHAINS(NC),
    .FIFO_DEPTH(DEPTH),
    .CNT_W     (16)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wbs_stb_i   (stb),
    .wbs_cyc_i   (cyc),
    .wbs_we_i    (we),
    .wbs_sel_i   (sel),
    .wbs_data_i  (wdat),
    .wbs_addr_i  (addr),
    .wbs_ack_o   (ack),
    .wbs_data_o  (rdat),
    .cen         (cen),
    .shift_en_out(shift_en),
    .shift_out   (shift_o),
    .set_out     (set_o),
    .busy        (busy_o)
  );

  // Record chain activity mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (shift_en) obs_q.push_back(shift_o);
      else if (shift_o != '0) zero_viol++;
      if (set_o) set_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic w, input logic [1:0] r, input logic [31:0] d,
                      input logic [3:0] s, input string tag, output logic [31:0] q);
    @(posedge clk);
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w; sel = s; wdat = d;
    addr = BASE | {28'd0, r, 2'b00};
    @(posedge clk); #1;
    check({tag, "_ack"}, {31'd0, ack}, 32'd1);
    q = rdat;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [1:0] r, input logic [31:0] d, input logic [3:0] s, input string tag);
    logic [31:0] q;
    xfer(1'b1, r, d, s, tag, q);
  endtask

  task automatic rd_chk(input logic [1:0] r, input logic [31:0] exp, input string tag);
    logic [31:0] q;
    xfer(1'b0, r, 32'd0, 4'hF, tag, q);
    check(tag, q, exp);
  endtask

  // DATA write; the model queue only accepts it when there is room.
  task automatic push_word(input logic [31:0] w);
    wr(R_DATA, w, 4'hF, "data_wr");
    if (mq.size() < DEPTH) mq.push_back(w);
  endtask

  // k-th chain slice of a run: word k/8 of the queue, nibble k%8, LSB first.
  function automatic logic [3:0] exp_nib(input int k);
    logic [31:0] w;
    w = mq[k / 8];
    return 4'(w >> (4 * (k % 8)));
  endfunction

  function automatic logic [31:0] exp_status(input logic ovf_exp);
    int n;
    n = mq.size();
    return (32'(n) << 8) | {28'd0, ovf_exp, (n == DEPTH), (n == 0), 1'b0};
  endfunction

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (busy_o && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_done"}, {31'd0, busy_o}, 32'd0);
  endtask

  // Compare a run's slices with the model, then retire the words it consumed.
  task automatic check_stream(input int base, input int len, input string tag);
    int bad;
    bad = 0;
    check({tag, "_len"}, 32'(obs_q.size() - base), 32'(len));
    for (int k = 0; k < len; k++) begin
      if (base + k >= obs_q.size()) bad++;
      else if (obs_q[base + k] !== exp_nib(k)) bad++;
    end
    check({tag, "_data"}, 32'(bad), 32'd0);
    for (int k = 0; k < (len + 7) / 8; k++) begin
      if (mq.size() > 0) void'(mq.pop_front());
    end
  endtask

  initial begin
    int ob;
    int sb;
    int acked;
    logic [31:0] w;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst0_ctl", {23'd0, ack, cen, shift_en, set_o, busy_o, shift_o}, 32'd0);
    check("rst0_data", rdat, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rd_chk(R_STAT, 32'h0000_0002, "rst0_status");
    rd_chk(R_CTRL, 32'd0, "rst0_ctrl");
    rd_chk(R_LEN, 32'd0, "rst0_len");

    // LENGTH byte lanes
    wr(R_LEN, 32'hFFFF_ABCD, 4'hF, "len_full");
    rd_chk(R_LEN, 32'h0000_ABCD, "len_full_rd");
    wr(R_LEN, 32'h1234_5500, 4'b0010, "len_byte1");
    rd_chk(R_LEN, 32'h0000_55CD, "len_byte1_rd");

    // Request held through its ack cycle is acked once
    @(posedge clk);
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; sel = 4'hF; addr = BASE | 32'h4;
    @(posedge clk); #1;
    check("held_ack1", {31'd0, ack}, 32'd1);
    check("held_data1", rdat, 32'h0000_55CD);
    @(posedge clk); #1;
    check("held_ack2", {31'd0, ack}, 32'd0);
    check("held_data2", rdat, 32'd0);
    @(negedge clk);
    stb = 1'b0; cyc = 1'b0;

    // Basic run with cycle-exact latency
    wr(R_LEN, 32'd8, 4'hF, "len8");
    push_word(32'h0000_00A5);
    ob = obs_q.size(); sb = set_cnt;
    wr(R_CTRL, 32'h3, 4'h1, "go_basic");
    check("basic_ackcycle", {30'd0, busy_o, shift_en}, 32'd0);
    @(posedge clk); #1;
    check("basic_load", {30'd0, busy_o, shift_en}, 32'h2);
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      check("basic_shift", {26'd0, busy_o, shift_en, shift_o}, {26'd0, 1'b1, 1'b1, exp_nib(c)});
    end
    @(posedge clk); #1;
    check("basic_set", {29'd0, busy_o, shift_en, set_o}, 32'h5);
    @(posedge clk); #1;
    check("basic_idle", {29'd0, busy_o, shift_en, set_o}, 32'd0);
    check("basic_setcnt", 32'(set_cnt - sb), 32'd1);
    check_stream(ob, 8, "basic");
    check("basic_cen", {31'd0, cen}, 32'd1);
    rd_chk(R_STAT, exp_status(1'b0), "basic_status");

    // Two-word run stalls in LOAD until the second word arrives
    wr(R_LEN, 32'd16, 4'hF, "len16");
    push_word($urandom);
    ob = obs_q.size(); sb = set_cnt;
    wr(R_CTRL, 32'h3, 4'h1, "go_stall");
    repeat (14) @(posedge clk);
    #1;
    check("stall_state", {30'd0, busy_o, shift_en}, 32'h2);
    check("stall_first8", 32'(obs_q.size() - ob), 32'd8);
    push_word($urandom);
    wait_idle(60, "stall");
    check_stream(ob, 16, "stall");
    check("stall_setcnt", 32'(set_cnt - sb), 32'd1);

    // Zero length: SET without shifting
    wr(R_LEN, 32'd0, 4'hF, "len0");
    ob = obs_q.size(); sb = set_cnt;
    wr(R_CTRL, 32'h3, 4'h1, "go_zero");
    @(posedge clk); #1;
    check("zero_set", {29'd0, busy_o, shift_en, set_o}, 32'h5);
    @(posedge clk); #1;
    check("zero_idle", {29'd0, busy_o, shift_en, set_o}, 32'd0);
    check("zero_noshift", 32'(obs_q.size() - ob), 32'd0);
    check("zero_setcnt", 32'(set_cnt - sb), 32'd1);

    // GO while busy is ignored
    wr(R_LEN, 32'd24, 4'hF, "len24");
    for (int p = 0; p < 3; p++) push_word($urandom);
    ob = obs_q.size(); sb = set_cnt;
    wr(R_CTRL, 32'h3, 4'h1, "go_run");
    wr(R_CTRL, 32'h3, 4'h1, "go_ignored");
    wait_idle(80, "busygo");
    check_stream(ob, 24, "busygo");
    repeat (6) @(posedge clk);
    #1;
    check("busygo_stays_idle", {31'd0, busy_o}, 32'd0);
    check("busygo_setcnt", 32'(set_cnt - sb), 32'd1);

    // Overflow and OVF clear
    for (int p = 0; p < 5; p++) push_word($urandom);
    rd_chk(R_STAT, exp_status(1'b1), "ovf_status");
    wr(R_STAT, 32'h8, 4'hF, "ovf_clear");
    rd_chk(R_STAT, exp_status(1'b0), "ovf_cleared");

    // Randomized runs against the queue model
    for (int it = 0; it < 8; it++) begin
      int len;
      int need;
      int npush;
      int spare;
      len   = int'($urandom_range(1, 32));
      need  = (len + 7) / 8;
      npush = (need > mq.size()) ? need - mq.size() : 0;
      spare = DEPTH - mq.size() - npush;
      if (spare > 0) npush += int'($urandom_range(0, spare));
      wr(R_LEN, 32'(len), 4'hF, "rnd_len");
      for (int p = 0; p < npush; p++) push_word($urandom);
      ob = obs_q.size(); sb = set_cnt;
      wr(R_CTRL, 32'h3, 4'h1, "rnd_go");
      wait_idle(len * 2 + 40, "rnd");
      check_stream(ob, len, "rnd");
      check("rnd_setcnt", 32'(set_cnt - sb), 32'd1);
      rd_chk(R_STAT, exp_status(1'b0), "rnd_status");
    end

    // Address decode: foreign address is never acked and has no effect
    wr(R_LEN, 32'd0, 4'hF, "len0b");
    sb = set_cnt;
    @(posedge clk);
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b1; sel = 4'hF; wdat = 32'h2; addr = 32'h4000_0000;
    acked = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ack) acked++;
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    check("decode_noack", 32'(acked), 32'd0);
    @(posedge clk); #1;
    check("decode_nobusy", {31'd0, busy_o}, 32'd0);
    check("decode_noset", 32'(set_cnt - sb), 32'd0);
    rd_chk(R_CTRL, 32'h1, "decode_ctrl");
    wr(R_CTRL, 32'h3, 4'h1, "go_readback");
    rd_chk(R_CTRL, 32'h1, "go_reads0");

    // Reset in the middle of SHIFT
    wr(R_LEN, 32'd16, 4'hF, "len16b");
    if (mq.size() < DEPTH) push_word($urandom);
    wr(R_CTRL, 32'h3, 4'h1, "go_rst");
    repeat (3) @(posedge clk);
    #1;
    check("prerst_shift", {31'd0, shift_en}, 32'd1);
    sb = set_cnt;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_ctl", {23'd0, ack, cen, shift_en, set_o, busy_o, shift_o}, 32'd0);
    check("rst_data", rdat, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    repeat (5) @(posedge clk);
    #1;
    check("rst_noset", 32'(set_cnt - sb), 32'd0);
    check("rst_idle", {31'd0, busy_o}, 32'd0);
    rd_chk(R_STAT, exp_status(1'b0), "rst_status");
    rd_chk(R_LEN, 32'd0, "rst_len");
    rd_chk(R_CTRL, 32'd0, "rst_ctrl");

    check("shift_out_zero_when_idle", 32'(zero_viol), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
